// File: rtl/shift_pkg.sv
// ----------------------------------------------------------------------------
// shift_pkg
// Definitions shared by the sequential right shifter and its datapath step.
//   SHIFT_N       : operand width (32 is the only width in use)
//   SHAMT_W       : width of a shift amount, 0..SHIFT_N-1
//   shift_state_t : control states IDLE / SHIFT / DONE
// ----------------------------------------------------------------------------
package shift_pkg;

   localparam int SHIFT_N = 32;
   localparam int SHAMT_W = $clog2(SHIFT_N);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } shift_state_t;

endpackage : shift_pkg

// File: rtl/shift_right_step.sv
// ----------------------------------------------------------------------------
// shift_right_step
// Combinational single-step right shift with an explicit fill bit. The step
// is 1 bit, or 4 bits when i_by4 is set (the fill is then replicated into
// the top 4 bits).
// Ports:
//   i_data [N-1:0] : value to shift
//   i_fill         : bit shifted in at the MSB end
//   i_by4          : 1 = shift by 4, 0 = shift by 1
//   o_data [N-1:0] : shifted value
// ----------------------------------------------------------------------------
module shift_right_step
   import shift_pkg::*;
#(
   parameter int N = SHIFT_N
) (
   input  logic [N-1:0] i_data,
   input  logic         i_fill,
   input  logic         i_by4,
   output logic [N-1:0] o_data
);

   always_comb begin
      if (i_by4) begin
         o_data = {{4{i_fill}}, i_data[N-1:4]};
      end else begin
         o_data = {i_fill, i_data[N-1:1]};
      end
   end

endmodule : shift_right_step

// File: rtl/shift_right_sequential.sv
// ----------------------------------------------------------------------------
// shift_right_sequential
// Multi-cycle logical / arithmetic right shifter with valid/ready handshakes
// on both the request and the result side. One request is in flight at a
// time; the result is held in DONE until the consumer takes it.
//
// Build option: macro SHIFT_STRIDE4_EN. When defined, the SHIFT state moves
// 4 bit positions per cycle while at least 4 remain, then 1 per cycle.
// When undefined, the shift is strictly 1 bit per cycle. Results and
// handshake behaviour are identical in both builds; only latency differs.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   in_valid   : request present
//   in_ready   : request can be accepted (IDLE only)
//   in_data    : operand
//   in_shamt   : shift amount 0..N-1
//   in_arith   : 1 = sign fill, 0 = zero fill
//   out_valid  : result present (DONE)
//   out_ready  : consumer takes the result
//   out_data   : result; meaningful only while out_valid = 1
//   busy       : any state other than IDLE
// ----------------------------------------------------------------------------
module shift_right_sequential
   import shift_pkg::*;
#(
   parameter int N = SHIFT_N
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0]         in_data,
   input  logic [$clog2(N)-1:0] in_shamt,
   input  logic                 in_arith,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N-1:0]         out_data,
   output logic                 busy
);

   localparam int SW = $clog2(N);

   shift_state_t r_state;
   shift_state_t w_state_nxt;
   logic [N-1:0]  r_work;
   logic [N-1:0]  w_work_nxt;
   logic [N-1:0]  w_step;
   logic [SW-1:0] r_remaining;
   logic [SW-1:0] w_remaining_nxt;
   logic [SW-1:0] w_dec;
   logic          r_fill;
   logic          w_fill_nxt;
   logic          w_by4;

`ifdef SHIFT_STRIDE4_EN
   assign w_by4 = (r_remaining >= SW'(4));
`else
   assign w_by4 = 1'b0;
`endif

   // Amount consumed by this cycle's step; the op ends when it uses up the
   // last remaining positions.
   assign w_dec = w_by4 ? SW'(4) : SW'(1);

   shift_right_step #(
      .N (N)
   ) u_step (
      .i_data (r_work),
      .i_fill (r_fill),
      .i_by4  (w_by4),
      .o_data (w_step)
   );

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path
      // through the case can leave one unassigned and infer a latch.
      w_state_nxt     = r_state;
      w_work_nxt      = r_work;
      w_remaining_nxt = r_remaining;
      w_fill_nxt      = r_fill;

      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_work_nxt      = in_data;
               w_remaining_nxt = in_shamt;
               w_fill_nxt      = in_arith & in_data[N-1];
               w_state_nxt     = (in_shamt == '0) ? S_DONE : S_SHIFT;
            end
         end
         S_SHIFT: begin
            w_work_nxt      = w_step;
            w_remaining_nxt = r_remaining - w_dec;
            if (r_remaining == w_dec) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      if (rst) begin
         r_state     <= S_IDLE;
         // NOTE: the working register is reset too, because it drives
         // out_data directly and that output must read zero after reset.
         r_work      <= '0;
         r_remaining <= '0;
         r_fill      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_work      <= w_work_nxt;
         r_remaining <= w_remaining_nxt;
         r_fill      <= w_fill_nxt;
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state != S_IDLE);
   assign out_data  = r_work;

endmodule : shift_right_sequential
